// File: rtl/rx_hexword.sv
// rx_hexword: 8N1 UART receiver plus "0x"+8 hex+CR+LF frame parser.
// Emits each well-formed frame's 32-bit value with a one-cycle strobe.
module rx_hexword #(
    parameter int CLOCKS_PER_BAUD = 868
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_uart_rx,
    output logic        o_stb,
    output logic [31:0] o_data,
    output logic        o_frame_err,
    output logic        o_parse_err
);

    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA, R_STOP, R_BREAK
    } r_state_t;

    typedef enum logic [2:0] {
        P_IDLE, P_X, P_HEX, P_CR, P_LF
    } p_state_t;

    // Loaded values are one less than the wanted distance because the
    // sample fires on the edge that sees a zero count.
    localparam logic [23:0] HALF_M1 = 24'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [23:0] FULL_M1 = 24'(CLOCKS_PER_BAUD - 1);

    logic        meta_q, meta_d;
    logic        rx_s_q, rx_s_d;

    r_state_t    r_state_q, r_state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        byte_stb_q, byte_stb_d;
    logic [7:0]  byte_q, byte_d;
    logic        frame_err_q, frame_err_d;

    p_state_t    p_state_q, p_state_d;
    logic [2:0]  dcnt_q, dcnt_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] data_q, data_d;
    logic        stb_q, stb_d;
    logic        perr_q, perr_d;

    logic        cnt_zero;
    logic        hex_ok;
    logic [3:0]  hex_nib;
    logic        bad;

    assign cnt_zero = (cnt_q == 24'd0);

    // Two-flop synchronizer next values.
    always_comb begin
        meta_d = i_uart_rx;
        rx_s_d = meta_q;
    end

    // Receiver: mid-bit sampling of start, 8 data bits LSB first, stop.
    always_comb begin
        r_state_d   = r_state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        byte_stb_d  = 1'b0;
        byte_d      = byte_q;
        frame_err_d = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                if (!rx_s_q) begin
                    cnt_d     = HALF_M1;
                    r_state_d = R_START;
                end
            end
            R_START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 24'd1;
                end else if (rx_s_q) begin
                    r_state_d = R_IDLE;
                end else begin
                    cnt_d     = FULL_M1;
                    bit_idx_d = 3'd0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 24'd1;
                end else begin
                    shreg_d = {rx_s_q, shreg_q[7:1]};
                    cnt_d   = FULL_M1;
                    if (bit_idx_q == 3'd7) begin
                        r_state_d = R_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            R_STOP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 24'd1;
                end else if (rx_s_q) begin
                    byte_stb_d = 1'b1;
                    byte_d     = shreg_q;
                    r_state_d  = R_IDLE;
                end else begin
                    frame_err_d = 1'b1;
                    r_state_d   = R_BREAK;
                end
            end
            R_BREAK: begin
                if (rx_s_q) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Hex digit classification of the received byte.
    always_comb begin
        hex_ok  = 1'b0;
        hex_nib = 4'd0;
        unique case (1'b1)
            (byte_q >= 8'h30 && byte_q <= 8'h39): begin
                hex_ok  = 1'b1;
                hex_nib = byte_q[3:0];
            end
            (byte_q >= 8'h41 && byte_q <= 8'h46),
            (byte_q >= 8'h61 && byte_q <= 8'h66): begin
                hex_ok  = 1'b1;
                hex_nib = byte_q[3:0] + 4'd9;
            end
            default: ;
        endcase
    end

    // Parser: walks the frame grammar one received byte at a time.
    always_comb begin
        p_state_d = p_state_q;
        dcnt_d    = dcnt_q;
        acc_d     = acc_q;
        data_d    = data_q;
        stb_d     = 1'b0;
        perr_d    = 1'b0;
        bad       = 1'b0;
        if (frame_err_q) begin
            p_state_d = P_IDLE;
        end else if (byte_stb_q) begin
            unique case (p_state_q)
                P_IDLE: begin
                    if (byte_q == 8'h30) p_state_d = P_X;
                end
                P_X: begin
                    if (byte_q == 8'h78 || byte_q == 8'h58) begin
                        p_state_d = P_HEX;
                        dcnt_d    = 3'd0;
                        acc_d     = 32'd0;
                    end else begin
                        bad = 1'b1;
                    end
                end
                P_HEX: begin
                    if (hex_ok) begin
                        acc_d = {acc_q[27:0], hex_nib};
                        if (dcnt_q == 3'd7) begin
                            p_state_d = P_CR;
                        end else begin
                            dcnt_d = dcnt_q + 3'd1;
                        end
                    end else begin
                        bad = 1'b1;
                    end
                end
                P_CR: begin
                    if (byte_q == 8'h0D) p_state_d = P_LF;
                    else                 bad = 1'b1;
                end
                P_LF: begin
                    if (byte_q == 8'h0A) begin
                        data_d    = acc_q;
                        stb_d     = 1'b1;
                        p_state_d = P_IDLE;
                    end else begin
                        bad = 1'b1;
                    end
                end
                default: p_state_d = P_IDLE;
            endcase
            // A stray '0' may be the start of the next frame.
            if (bad) begin
                perr_d    = 1'b1;
                p_state_d = (byte_q == 8'h30) ? P_X : P_IDLE;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            meta_q      <= 1'b1;
            rx_s_q      <= 1'b1;
            r_state_q   <= R_IDLE;
            cnt_q       <= 24'd0;
            bit_idx_q   <= 3'd0;
            shreg_q     <= 8'd0;
            byte_stb_q  <= 1'b0;
            byte_q      <= 8'd0;
            frame_err_q <= 1'b0;
            p_state_q   <= P_IDLE;
            dcnt_q      <= 3'd0;
            acc_q       <= 32'd0;
            data_q      <= 32'd0;
            stb_q       <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            meta_q      <= meta_d;
            rx_s_q      <= rx_s_d;
            r_state_q   <= r_state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            byte_stb_q  <= byte_stb_d;
            byte_q      <= byte_d;
            frame_err_q <= frame_err_d;
            p_state_q   <= p_state_d;
            dcnt_q      <= dcnt_d;
            acc_q       <= acc_d;
            data_q      <= data_d;
            stb_q       <= stb_d;
            perr_q      <= perr_d;
        end
    end

    assign o_stb       = stb_q;
    assign o_data      = data_q;
    assign o_frame_err = frame_err_q;
    assign o_parse_err = perr_q;

endmodule
